// File: rtl/reg_scoreboard.sv
// reg_scoreboard
// Decode-stage register scoreboard. Each tracked register has a saturating-free
// outstanding-write counter: it increments when a writing instruction leaves
// decode and decrements when that write retires at writeback. Decode stalls on
// a source whose counter is nonzero unless forwarding can supply the value.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   issue_valid      decode holds an instruction wanting to issue
//   issue_ready      instruction may issue this cycle (independent of issue_valid)
//   issue_we         instruction writes a GPR
//   issue_dest       destination register index
//   issue_src        packed source indices, src i at [i*AW +: AW]
//   issue_src_en     source i is actually read
//   src_fwd_ok       forwarding can supply source i this cycle
//   wb_valid         a GPR write retires this cycle
//   wb_dest          retiring register index
//   flush            discard all outstanding entries
//   stall            issue blocked by a data hazard
//   hazard_src       per-source hazard flag
//   busy_vec         bit r set when counter r is nonzero
//   pending_total    sum of all counters
//   err              sticky: writeback to a register with no outstanding write
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 2,
    parameter int NSRC  = 2,
    parameter int TOT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 issue_valid,
    output logic                 issue_ready,
    input  logic                 issue_we,
    input  logic [AW-1:0]        issue_dest,
    input  logic [NSRC*AW-1:0]   issue_src,
    input  logic [NSRC-1:0]      issue_src_en,
    input  logic [NSRC-1:0]      src_fwd_ok,
    input  logic                 wb_valid,
    input  logic [AW-1:0]        wb_dest,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC-1:0]      hazard_src,
    output logic [NREG-1:0]      busy_vec,
    output logic [TOT_W-1:0]     pending_total,
    output logic                 err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

    logic [NREG-1:0][CNT_W-1:0] w_cnt;
    logic [NREG-1:0]            w_nz;
    logic [NSRC-1:0]            w_src_busy;
    logic                       w_dest_full;
    logic                       w_wb_nz;
    logic                       w_issue_fire;
    logic                       w_inc_any;
    logic                       w_dec_any;
    logic [TOT_W-1:0]           r_total;
    logic                       r_err;

    // Register 0 is hard-wired zero and never tracked.
    assign w_cnt[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_reg
            logic [CNT_W-1:0] r_cnt;
            logic             w_inc;
            logic             w_dec;

            assign w_inc = w_issue_fire & issue_we & (issue_dest == AW'(gi));
            // Decrement only a nonzero counter; a stray writeback is an error, not an underflow.
            assign w_dec = wb_valid & (wb_dest == AW'(gi)) & (r_cnt != '0);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_cnt <= '0;
                end else if (flush) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(w_inc) - CNT_W'(w_dec);
                end
            end

            assign w_cnt[gi] = r_cnt;
        end

        for (gi = 0; gi < NREG; gi++) begin : g_nz
            assign w_nz[gi] = (w_cnt[gi] != '0);
        end
    endgenerate

    // Index lookups: compare against every tracked register so that indices
    // beyond NREG (when 2^AW > NREG) simply read as not busy.
    always_comb begin
        w_src_busy  = '0;
        w_dest_full = 1'b0;
        w_wb_nz     = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            for (int s = 0; s < NSRC; s++) begin
                if (issue_src[s*AW +: AW] == AW'(r)) begin
                    w_src_busy[s] = w_nz[r];
                end
            end
            if (issue_dest == AW'(r)) begin
                w_dest_full = (w_cnt[r] == CNT_MAX);
            end
            if (wb_dest == AW'(r)) begin
                w_wb_nz = w_nz[r];
            end
        end
    end

    assign hazard_src   = issue_src_en & w_src_busy & ~src_fwd_ok;
    assign stall        = issue_valid & (|hazard_src);
    assign issue_ready  = ~(|hazard_src) & ~(issue_we & w_dest_full) & ~flush
                          & (r_total != TOT_MAX);
    assign w_issue_fire = issue_valid & issue_ready;

    // Aggregate inc/dec mirror the per-register rules so the total always
    // equals the sum of the counters.
    assign w_inc_any = w_issue_fire & issue_we & (issue_dest != '0);
    assign w_dec_any = wb_valid & (wb_dest != '0) & w_wb_nz;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_total <= '0;
            r_err   <= 1'b0;
        end else begin
            if (flush) begin
                r_total <= '0;
            end else begin
                r_total <= r_total + TOT_W'(w_inc_any) - TOT_W'(w_dec_any);
            end
            if (wb_valid && (wb_dest != '0) && !w_wb_nz && !flush) begin
                r_err <= 1'b1;
            end
        end
    end

    assign busy_vec      = w_nz;
    assign pending_total = r_total;
    assign err           = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard. Inputs change 1 ns after the rising
// edge; outputs are checked 1 ns later, well before the next edge.
module tb_reg_scoreboard;

    localparam int NREG  = 32;
    localparam int AW    = 5;
    localparam int NSRC  = 2;
    localparam int TOT_W = 6;

    logic               clk;
    logic               reset;
    logic               issue_valid;
    logic               issue_ready;
    logic               issue_we;
    logic [AW-1:0]      issue_dest;
    logic [NSRC*AW-1:0] issue_src;
    logic [NSRC-1:0]    issue_src_en;
    logic [NSRC-1:0]    src_fwd_ok;
    logic               wb_valid;
    logic [AW-1:0]      wb_dest;
    logic               flush;
    logic               stall;
    logic [NSRC-1:0]    hazard_src;
    logic [NREG-1:0]    busy_vec;
    logic [TOT_W-1:0]   pending_total;
    logic               err;

    int errors = 0;
    int checks = 0;

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_we      (issue_we),
        .issue_dest    (issue_dest),
        .issue_src     (issue_src),
        .issue_src_en  (issue_src_en),
        .src_fwd_ok    (src_fwd_ok),
        .wb_valid      (wb_valid),
        .wb_dest       (wb_dest),
        .flush         (flush),
        .stall         (stall),
        .hazard_src    (hazard_src),
        .busy_vec      (busy_vec),
        .pending_total (pending_total),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_we     = 1'b0;
        issue_dest   = '0;
        issue_src    = '0;
        issue_src_en = '0;
        src_fwd_ok   = '0;
        wb_valid     = 1'b0;
        wb_dest      = '0;
        flush        = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        chk("reset_busy", 64'(busy_vec), 64'h0);
        chk("reset_total", 64'(pending_total), 64'h0);
        chk("reset_err", 64'(err), 64'h0);
        tick();
        tick();
        reset = 1'b0;

        // Issue a write to r5.
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd5;
        #1;
        chk("issue5_ready", 64'(issue_ready), 64'h1);
        chk("issue5_stall", 64'(stall), 64'h0);
        tick();
        idle();
        #1;
        chk("busy5", 64'(busy_vec), 64'h20);
        chk("total_1", 64'(pending_total), 64'h1);

        // Read r5 without forwarding -> hazard; with forwarding -> clear.
        issue_valid = 1'b1; issue_src = {5'd0, 5'd5}; issue_src_en = 2'b01; src_fwd_ok = 2'b00;
        #1;
        chk("raw_stall", 64'(stall), 64'h1);
        chk("raw_hazard", 64'(hazard_src), 64'h1);
        chk("raw_ready", 64'(issue_ready), 64'h0);
        src_fwd_ok = 2'b01;
        #1;
        chk("fwd_stall", 64'(stall), 64'h0);
        chk("fwd_hazard", 64'(hazard_src), 64'h0);
        chk("fwd_ready", 64'(issue_ready), 64'h1);
        tick();
        idle();

        // Three writes to r7 fill its 2-bit counter.
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd7;
        tick();
        tick();
        tick();
        #1;
        chk("r7_full_ready", 64'(issue_ready), 64'h0);
        chk("r7_full_total", 64'(pending_total), 64'h4);
        chk("r7_busy", 64'(busy_vec), 64'hA0);
        tick();
        chk("r7_blocked_total", 64'(pending_total), 64'h4);
        idle();
        wb_valid = 1'b1; wb_dest = 5'd7;
        tick();
        idle();
        #1;
        chk("r7_wb_total", 64'(pending_total), 64'h3);
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd7;
        #1;
        chk("r7_ready_again", 64'(issue_ready), 64'h1);
        tick();
        idle();
        #1;
        chk("r7_refill_total", 64'(pending_total), 64'h4);

        // r9: issue once, then issue and writeback in the same cycle.
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd9;
        tick();
        chk("r9_total", 64'(pending_total), 64'h5);
        wb_valid = 1'b1; wb_dest = 5'd9;
        tick();
        idle();
        #1;
        chk("r9_same_total", 64'(pending_total), 64'h5);
        chk("r9_busy", 64'(busy_vec), 64'h2A0);

        // Register 0 is never tracked.
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd0;
        issue_src = '0; issue_src_en = 2'b11; src_fwd_ok = 2'b00;
        #1;
        chk("r0_hazard", 64'(hazard_src), 64'h0);
        chk("r0_stall", 64'(stall), 64'h0);
        chk("r0_ready", 64'(issue_ready), 64'h1);
        tick();
        idle();
        wb_valid = 1'b1; wb_dest = 5'd0;
        tick();
        idle();
        #1;
        chk("r0_total", 64'(pending_total), 64'h5);
        chk("r0_busy", 64'(busy_vec), 64'h2A0);
        chk("r0_wb_err", 64'(err), 64'h0);

        // Writeback to idle r12 sets sticky err and changes nothing else.
        wb_valid = 1'b1; wb_dest = 5'd12;
        tick();
        idle();
        #1;
        chk("r12_err", 64'(err), 64'h1);
        chk("r12_total", 64'(pending_total), 64'h5);
        chk("r12_busy", 64'(busy_vec), 64'h2A0);
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd3;
        tick();
        idle();
        #1;
        chk("err_sticky", 64'(err), 64'h1);
        chk("r3_total", 64'(pending_total), 64'h6);
        chk("four_busy", 64'(busy_vec), 64'h2A8);

        // Flush wins over same-cycle issue and writeback.
        flush = 1'b1;
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd10;
        wb_valid = 1'b1; wb_dest = 5'd5;
        #1;
        chk("flush_ready", 64'(issue_ready), 64'h0);
        tick();
        idle();
        #1;
        chk("flush_busy", 64'(busy_vec), 64'h0);
        chk("flush_total", 64'(pending_total), 64'h0);
        chk("flush_err_kept", 64'(err), 64'h1);

        // Reset mid-cycle clears state without a clock edge.
        issue_valid = 1'b1; issue_we = 1'b1; issue_dest = 5'd4;
        tick();
        idle();
        #1;
        chk("r4_busy", 64'(busy_vec), 64'h10);
        reset = 1'b1;
        #1;
        chk("async_busy", 64'(busy_vec), 64'h0);
        chk("async_total", 64'(pending_total), 64'h0);
        chk("async_err", 64'(err), 64'h0);
        tick();
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised register scoreboard for the decode stage. It generalises the single-stage block/forward check into per-register outstanding-write counters. Each counter is incremented when a writing instruction issues out of decode and decremented when that write retires at writeback. Decode uses its stall output in place of ad-hoc dest comparisons, so that multi-cycle producers (div/mult, loads) and any number of in-flight stages are handled uniformly.

Parameters:
NREG, 32, number of architectural registers; register 0 is hard-wired zero and never tracked.
AW, 5, register index width; must satisfy 2^AW >= NREG.
CNT_W, 2, per-register counter width; at most 2^CNT_W-1 outstanding writes per register.
NSRC, 2, number of source operands checked per issuing instruction.
TOT_W, 6, width of total-outstanding counter.

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
issue_valid  in  1  decode holds an instruction wanting to leave decode
issue_ready  out  1  instruction may issue this cycle
issue_we  in  1  instruction writes a GPR
issue_dest  in  AW  destination register index
issue_src  in  NSRC*AW  packed source indices; src i at [i*AW +: AW]
issue_src_en  in  NSRC  source i is actually read
src_fwd_ok  in  NSRC  forwarding network can supply source i this cycle
wb_valid  in  1  a GPR write retires this cycle
wb_dest  in  AW  retiring register index
flush  in  1  discard all outstanding entries (exception/eret)
stall  out  1  issue blocked by data hazard
hazard_src  out  NSRC  per-source hazard flag
busy_vec  out  NREG  bit r = counter r nonzero (registered)
pending_total  out  TOT_W  sum of all counters
err  out  1  sticky: writeback to non-busy register

Behaviour:
- Reset (async, active-high): all counters 0, pending_total 0, err 0, busy_vec 0. Once reset deasserts, no issue is possible while flush is high.
- hazard_src[i] = issue_src_en[i] & (src_i != 0) & (cnt[src_i] != 0) & ~src_fwd_ok[i]. This is combinational from registered counters and inputs.
- stall = issue_valid & |hazard_src.
- dest_full = issue_we & (issue_dest != 0) & (cnt[issue_dest] == 2^CNT_W-1).
- issue_ready = ~|hazard_src & ~dest_full & ~flush & (pending_total != 2^TOT_W-1). issue_ready does not depend on issue_valid.
- issue_fire = issue_valid & issue_ready.
- inc_r = issue_fire & issue_we & issue_dest==r & r!=0.
- dec_r = wb_valid & wb_dest==r & r!=0 & cnt[r]!=0.
- Per-register next state at posedge clk: flush -> 0; else cnt + inc_r - dec_r. Simultaneous inc and dec on the same register leaves the count unchanged. A write to register 0 is never counted.
- pending_total tracks the sum of all counters with the same inc/dec rules and is cleared by flush. It must always equal the popcount-weighted sum of the counters.
- err is set when wb_valid & wb_dest!=0 & cnt[wb_dest]==0 & ~flush. It is sticky until reset. The offending writeback changes no state.
- flush has priority over same-cycle issue and wb; both are discarded. wb_valid during flush does not set err.
- busy_vec[0] is always 0. busy_vec updates one cycle after the inc/dec.
- There is no self-issue dependency on the same cycle's writeback. A wb to a register in cycle T clears busy only from T+1; in cycle T itself, forwarding (src_fwd_ok) must cover the value.
- Latency: issue -> busy visible next cycle; wb -> not-busy next cycle.

Test Plan:
- Reset then issue_we dest=5, issue_valid=1 -> issue_ready=1. Next cycle busy_vec[5]=1, pending_total=1. Then src0=5, en=1, fwd_ok=0 -> stall=1, hazard_src=2'b01. Set fwd_ok=1 -> stall=0.
- Three issues to dest=7 with CNT_W=2 -> cnt=3. A fourth issue to dest 7 -> issue_ready=0. One wb_dest=7 -> next cycle issue_ready=1, cnt=2.
- Same cycle: issue dest=9 and wb_dest=9 with cnt[9]=1 -> cnt[9] stays 1 and pending_total is unchanged.
- Issue dest=0 and src=0 -> never busy, never hazard, pending_total unchanged. wb_dest=0 -> err stays 0.
- wb_dest=12 with cnt[12]=0 -> err=1 next cycle and remains 1 after further traffic until reset.
- With 4 registers busy, assert flush together with issue_valid and wb_valid -> issue_ready=0, and next cycle all busy_vec=0 and pending_total=0. Asserting reset mid-sequence clears all state immediately, without waiting for a clock edge.
